axil_master_engine: RTL and testbench
=====================================

Name: axil_master_engine

Overview:
Synthesisable, parametrised AXI4-Lite master that issues single read or write transactions from a simple valid/ready command port.
- Handles AW and W handshakes independently, in either order.
- Returns read data and response codes on a response port.
- Flags stalled slaves with a cycle timeout.
- Drives the BCP accelerator's S_AXI slave ports from on-chip sequencers and self-test logic.

Parameters:
C_M_AXI_ADDR_WIDTH, 32, address width.
C_M_AXI_DATA_WIDTH, 32, data width; legal values are 32 and 64.
TIMEOUT_CYCLES, 1024, busy cycles before timeout_err is set; 0 disables the timeout.

Ports:
M_AXI_ACLK  in  1  clock; all logic is on the rising edge.
M_AXI_ARESETN  in  1  asynchronous, active-low reset.
cmd_valid  in  1  command valid.
cmd_ready  out  1  engine accepts a command.
cmd_write  in  1  1 = write, 0 = read.
cmd_addr  in  C_M_AXI_ADDR_WIDTH  target address.
cmd_wdata  in  C_M_AXI_DATA_WIDTH  write data.
cmd_wstrb  in  C_M_AXI_DATA_WIDTH/8  byte strobes.
rsp_valid  out  1  response valid.
rsp_ready  in  1  consumer ready.
rsp_write  out  1  response belongs to a write.
rsp_rdata  out  C_M_AXI_DATA_WIDTH  read data; zero for writes.
rsp_resp  out  2  BRESP or RRESP.
timeout_err  out  1  sticky stall flag.
busy  out  1  state is not IDLE.
M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY, M_AXI_ARADDR/ARPROT/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master directions and widths. AWPROT and ARPROT are tied to 3'b000.

Behaviour:
- Reset (asserted asynchronously, at any time including mid-transaction):
  - state = IDLE.
  - All VALID/READY outputs, cmd_ready, rsp_valid, busy and timeout_err = 0.
  - All address, data, strobe and response registers = 0.
  - cmd_ready rises on the first clock edge after reset deasserts.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE:
  - cmd_ready = 1; no other state asserts cmd_ready.
  - On cmd_valid && cmd_ready: register addr, wdata, wstrb and write; go to WR_REQ or RD_REQ.
  - In the next cycle AWVALID and WVALID (write) or ARVALID (read) are 1, driven from registers.
- WR_REQ:
  - Per-channel done flags aw_done and w_done.
  - AWVALID = !aw_done and WVALID = !w_done.
  - Each VALID stays high until its own handshake edge, then drops the next cycle. A VALID is never withdrawn before its handshake.
  - Both handshakes on the same edge is legal.
  - When both flags are set (or are completing this edge): go to WR_RESP and clear the flags.
- WR_RESP:
  - BREADY = 1.
  - On BVALID: latch BRESP, rsp_write = 1, rsp_rdata = 0; go to RSP.
- RD_REQ: ARVALID held until ARREADY, then RD_DATA.
- RD_DATA:
  - RREADY = 1.
  - On RVALID: latch RDATA and RRESP, rsp_write = 0; go to RSP.
- RSP:
  - rsp_valid = 1, with outputs stable until rsp_ready.
  - On rsp_valid && rsp_ready: go to IDLE, with cmd_ready = 1 the next cycle.
- Latency with an always-ready slave that returns its response in the first cycle it may:
  - Write: accept edge N, AW/W handshake edge N+1, B handshake edge N+2, rsp_valid in cycle N+3.
  - Read: same timing, with AR and R in place of AW/W and B.
- SLVERR and DECERR are passed through on rsp_resp; they do not set timeout_err.
- Timeout:
  - A counter clears on command accept and increments in WR_REQ, WR_RESP, RD_REQ and RD_DATA.
  - When it reaches TIMEOUT_CYCLES, timeout_err is set; it is sticky until reset. The counter saturates.
  - The engine keeps waiting; the AXI VALID rules stay intact.
- Protocol rule: BREADY/RREADY are never asserted outside WR_RESP/RD_DATA.
- Width rule: cmd_wstrb maps directly to WSTRB.

Test Plan:
- Reset, then write data i = 0..15 to address 0x0 with an always-ready slave → each rsp_valid 3 cycles after accept, rsp_resp = 2'b00; slave register reads back 0x0000000F.
- Write 0xA5A5_0001 to 0x4, with WREADY immediate and AWREADY delayed 3 cycles → WVALID drops after 1 cycle, AWVALID is held 4 cycles, exactly one B accepted, rsp_write = 1.
- Read 0x8, slave returns RDATA = 0xDEADBEEF and RRESP = 2'b10 → rsp_rdata = 0xDEADBEEF, rsp_resp = 2'b10, timeout_err = 0.
- Hold rsp_ready = 0 for 5 cycles after a read → rsp_valid and rsp_rdata stable throughout; cmd_ready = 0 until the cycle after rsp_ready.
- TIMEOUT_CYCLES = 16, slave never asserts AWREADY → timeout_err = 1 after 16 busy cycles, AWVALID stays 1; async reset mid-wait clears all outputs immediately.
- C_M_AXI_DATA_WIDTH = 64: write 0x0123456789ABCDEF with wstrb 8'hF0 → WDATA and WSTRB match on the bus; read-back on the 64-bit RDATA path returns the data.

Source files
------------

// File: rtl/axil_master_engine.sv
// rtl/axil_master_engine.sv - single-outstanding AXI4-Lite master driven by a valid/ready command port
//
// Ports:
//   M_AXI_ACLK, M_AXI_ARESETN      clock (rising edge) and asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake; cmd_write selects write (1) or read (0)
//   cmd_addr/cmd_wdata/cmd_wstrb   target address, write data and byte strobes
//   rsp_valid/rsp_ready            response handshake
//   rsp_write/rsp_rdata/rsp_resp   response kind, read data (zero for writes), BRESP/RRESP
//   timeout_err                    sticky flag: a transaction waited TIMEOUT_CYCLES busy cycles
//   busy                           engine is not idle
//   M_AXI_*                        AXI4-Lite master channels AW, W, B, AR, R

`timescale 1ns/1ps

module axil_master_engine #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESETN,

    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,

    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic                              rsp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,

    output logic                              timeout_err,
    output logic                              busy,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,

    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,

    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,

    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int SW = C_M_AXI_DATA_WIDTH / 8;
    // Counter just wide enough to hold TIMEOUT_CYCLES; a 1-bit stub when disabled.
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_DATA = 3'd4,
        S_RSP     = 3'd5
    } state_t;

    state_t state_q;
    state_t state_d;

    // Keeps cmd_ready low while reset is held and until the first edge after release.
    logic                            live_q;

    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
    logic [SW-1:0]                   wstrb_q;
    logic                            aw_done_q;
    logic                            w_done_q;

    logic                            rsp_write_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata_q;
    logic [1:0]                      rsp_resp_q;

    logic [TW-1:0]                   tmo_cnt_q;
    logic [TW-1:0]                   tmo_cnt_inc;
    logic                            timeout_err_q;

    logic                            cmd_fire;
    logic                            aw_hs;
    logic                            w_hs;
    logic                            waiting;

    assign cmd_fire    = cmd_valid && cmd_ready;
    assign aw_hs       = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs        = M_AXI_WVALID && M_AXI_WREADY;
    assign waiting     = (state_q == S_WR_REQ) || (state_q == S_WR_RESP) ||
                         (state_q == S_RD_REQ) || (state_q == S_RD_DATA);
    assign tmo_cnt_inc = tmo_cnt_q + 1'b1;

    // Address, data and strobe come straight from the command registers.
    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_ARADDR = addr_q;
    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_WSTRB  = wstrb_q;
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;

    assign rsp_write   = rsp_write_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;
    assign timeout_err = timeout_err_q;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cmd_ready     = 1'b0;
        rsp_valid     = 1'b0;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        busy          = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                cmd_ready = live_q;
                if (cmd_valid && live_q) begin
                    state_d = cmd_write ? S_WR_REQ : S_RD_REQ;
                end
            end
            S_WR_REQ: begin
                // Each channel drops its VALID only after its own handshake.
                M_AXI_AWVALID = !aw_done_q;
                M_AXI_WVALID  = !w_done_q;
                if ((aw_done_q || M_AXI_AWREADY) && (w_done_q || M_AXI_WREADY)) begin
                    state_d = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                M_AXI_BREADY = 1'b1;
                if (M_AXI_BVALID) begin
                    state_d = S_RSP;
                end
            end
            S_RD_REQ: begin
                M_AXI_ARVALID = 1'b1;
                if (M_AXI_ARREADY) begin
                    state_d = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                M_AXI_RREADY = 1'b1;
                if (M_AXI_RVALID) begin
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            live_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
        end else begin
            live_q <= 1'b1;

            if (cmd_fire) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
            end

            if (state_q == S_WR_REQ) begin
                if (state_d == S_WR_RESP) begin
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                end else begin
                    if (aw_hs) begin
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        w_done_q <= 1'b1;
                    end
                end
            end

            if ((state_q == S_WR_RESP) && M_AXI_BVALID) begin
                rsp_write_q <= 1'b1;
                rsp_rdata_q <= '0;
                rsp_resp_q  <= M_AXI_BRESP;
            end

            if ((state_q == S_RD_DATA) && M_AXI_RVALID) begin
                rsp_write_q <= 1'b0;
                rsp_rdata_q <= M_AXI_RDATA;
                rsp_resp_q  <= M_AXI_RRESP;
            end
        end
    end

    // Stall watchdog: counts cycles spent waiting on the slave for the current
    // command. It only reports; the transaction keeps waiting with VALIDs intact.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (cmd_fire) begin
                tmo_cnt_q <= '0;
            end else if (waiting && (tmo_cnt_q != TMO_LIMIT)) begin
                tmo_cnt_q <= tmo_cnt_inc;
                if ((TIMEOUT_CYCLES > 0) && (tmo_cnt_inc == TMO_LIMIT)) begin
                    timeout_err_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axil_master_engine.sv
// tb/tb_axil_master_engine.sv - self-checking bench for axil_master_engine (32-bit and 64-bit instances)

`timescale 1ns/1ps

module tb_axil_master_engine;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- 32-bit instance, TIMEOUT_CYCLES = 16 ----------------
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        timeout_err, busy;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [2:0]  m_awprot, m_arprot;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;

    axil_master_engine #(
        .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
    ) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .timeout_err(timeout_err), .busy(busy),
        .M_AXI_AWADDR(m_awaddr), .M_AXI_AWPROT(m_awprot), .M_AXI_AWVALID(m_awvalid), .M_AXI_AWREADY(m_awready),
        .M_AXI_WDATA(m_wdata), .M_AXI_WSTRB(m_wstrb), .M_AXI_WVALID(m_wvalid), .M_AXI_WREADY(m_wready),
        .M_AXI_BRESP(m_bresp), .M_AXI_BVALID(m_bvalid), .M_AXI_BREADY(m_bready),
        .M_AXI_ARADDR(m_araddr), .M_AXI_ARPROT(m_arprot), .M_AXI_ARVALID(m_arvalid), .M_AXI_ARREADY(m_arready),
        .M_AXI_RDATA(m_rdata), .M_AXI_RRESP(m_rresp), .M_AXI_RVALID(m_rvalid), .M_AXI_RREADY(m_rready)
    );

    // Slave behaviour knobs: each READY/VALID is delayed by the given cycles.
    int       cfg_aw_dly, cfg_w_dly, cfg_b_dly, cfg_ar_dly, cfg_r_dly;
    logic [1:0] cfg_bresp, cfg_rresp;

    int          aw_wait, w_wait, ar_wait, b_wait, r_wait;
    logic        have_aw, have_w, have_ar, s_bvalid, s_rvalid;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [3:0]  s_wstrb;
    logic [31:0] smem [0:15];
    logic        aw_hs, w_hs, ar_hs, b_hs, r_hs;

    assign m_awready = m_awvalid && (aw_wait >= cfg_aw_dly);
    assign m_wready  = m_wvalid  && (w_wait  >= cfg_w_dly);
    assign m_arready = m_arvalid && (ar_wait >= cfg_ar_dly);
    assign m_bvalid  = s_bvalid;
    assign m_bresp   = cfg_bresp;
    assign m_rvalid  = s_rvalid;
    assign m_rdata   = s_rdata;
    assign m_rresp   = cfg_rresp;
    assign aw_hs = m_awvalid && m_awready;
    assign w_hs  = m_wvalid && m_wready;
    assign ar_hs = m_arvalid && m_arready;
    assign b_hs  = m_bvalid && m_bready;
    assign r_hs  = m_rvalid && m_rready;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_wait <= 0; r_wait <= 0;
            have_aw <= 1'b0; have_w <= 1'b0; have_ar <= 1'b0;
            s_bvalid <= 1'b0; s_rvalid <= 1'b0;
            s_awaddr <= '0; s_wdata <= '0; s_araddr <= '0; s_rdata <= '0; s_wstrb <= '0;
            for (int i = 0; i < 16; i++) smem[i] <= '0;
        end else begin
            if (aw_hs) begin have_aw <= 1'b1; s_awaddr <= m_awaddr; aw_wait <= 0; end
            else if (m_awvalid) aw_wait <= aw_wait + 1;
            if (w_hs) begin have_w <= 1'b1; s_wdata <= m_wdata; s_wstrb <= m_wstrb; w_wait <= 0; end
            else if (m_wvalid) w_wait <= w_wait + 1;
            if (ar_hs) begin have_ar <= 1'b1; s_araddr <= m_araddr; ar_wait <= 0; end
            else if (m_arvalid) ar_wait <= ar_wait + 1;

            if (b_hs) begin
                s_bvalid <= 1'b0; have_aw <= 1'b0; have_w <= 1'b0; b_wait <= 0;
                for (int k = 0; k < 4; k++)
                    if (s_wstrb[k]) smem[s_awaddr[5:2]][8*k +: 8] <= s_wdata[8*k +: 8];
            end else if (!s_bvalid && (have_aw || aw_hs) && (have_w || w_hs)) begin
                if (b_wait >= cfg_b_dly) s_bvalid <= 1'b1;
                else b_wait <= b_wait + 1;
            end

            if (r_hs) begin
                s_rvalid <= 1'b0; have_ar <= 1'b0; r_wait <= 0;
            end else if (!s_rvalid && (have_ar || ar_hs)) begin
                if (r_wait >= cfg_r_dly) begin
                    s_rvalid <= 1'b1;
                    s_rdata  <= smem[ar_hs ? m_araddr[5:2] : s_araddr[5:2]];
                end else r_wait <= r_wait + 1;
            end
        end
    end

    // Bus monitor: VALID must not drop (or its payload change) before READY,
    // BREADY/RREADY only while busy and never together, PROT always zero.
    int   n_awv = 0, n_wv = 0, n_bhs = 0, n_viol = 0;
    logic pend_aw = 1'b0, pend_w = 1'b0, pend_ar = 1'b0;
    logic [31:0] hold_aw = '0, hold_w = '0, hold_ar = '0;
    logic bad;
    assign bad = (pend_aw && (!m_awvalid || m_awaddr != hold_aw)) ||
                 (pend_w  && (!m_wvalid  || m_wdata  != hold_w))  ||
                 (pend_ar && (!m_arvalid || m_araddr != hold_ar)) ||
                 ((m_bready || m_rready) && !busy) || (m_bready && m_rready) ||
                 (m_awprot != 3'b000) || (m_arprot != 3'b000);

    always @(posedge clk) begin
        if (!rst_n) begin
            pend_aw <= 1'b0; pend_w <= 1'b0; pend_ar <= 1'b0;
        end else begin
            if (bad) n_viol <= n_viol + 1;
            pend_aw <= m_awvalid && !m_awready; hold_aw <= m_awaddr;
            pend_w  <= m_wvalid  && !m_wready;  hold_w  <= m_wdata;
            pend_ar <= m_arvalid && !m_arready; hold_ar <= m_araddr;
            if (m_awvalid) n_awv <= n_awv + 1;
            if (m_wvalid)  n_wv  <= n_wv + 1;
            if (b_hs)      n_bhs <= n_bhs + 1;
        end
    end

    // ---------------- 64-bit instance, always-ready slave ----------------
    logic        x_cmd_valid, x_cmd_ready, x_cmd_write;
    logic [31:0] x_cmd_addr;
    logic [63:0] x_cmd_wdata, x_rsp_rdata, x_wdata, x_rdata;
    logic [7:0]  x_cmd_wstrb, x_wstrb;
    logic        x_rsp_valid, x_rsp_ready, x_rsp_write, x_timeout_err, x_busy;
    logic [1:0]  x_rsp_resp;
    logic [31:0] x_awaddr, x_araddr;
    logic [2:0]  x_awprot, x_arprot;
    logic        x_awvalid, x_awready, x_wvalid, x_wready, x_bvalid, x_bready;
    logic        x_arvalid, x_arready, x_rvalid, x_rready;

    axil_master_engine #(
        .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(64), .TIMEOUT_CYCLES(1024)
    ) dut64 (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .cmd_valid(x_cmd_valid), .cmd_ready(x_cmd_ready), .cmd_write(x_cmd_write),
        .cmd_addr(x_cmd_addr), .cmd_wdata(x_cmd_wdata), .cmd_wstrb(x_cmd_wstrb),
        .rsp_valid(x_rsp_valid), .rsp_ready(x_rsp_ready), .rsp_write(x_rsp_write),
        .rsp_rdata(x_rsp_rdata), .rsp_resp(x_rsp_resp),
        .timeout_err(x_timeout_err), .busy(x_busy),
        .M_AXI_AWADDR(x_awaddr), .M_AXI_AWPROT(x_awprot), .M_AXI_AWVALID(x_awvalid), .M_AXI_AWREADY(x_awready),
        .M_AXI_WDATA(x_wdata), .M_AXI_WSTRB(x_wstrb), .M_AXI_WVALID(x_wvalid), .M_AXI_WREADY(x_wready),
        .M_AXI_BRESP(2'b00), .M_AXI_BVALID(x_bvalid), .M_AXI_BREADY(x_bready),
        .M_AXI_ARADDR(x_araddr), .M_AXI_ARPROT(x_arprot), .M_AXI_ARVALID(x_arvalid), .M_AXI_ARREADY(x_arready),
        .M_AXI_RDATA(x_rdata), .M_AXI_RRESP(2'b00), .M_AXI_RVALID(x_rvalid), .M_AXI_RREADY(x_rready)
    );

    logic        x_have_aw, x_have_w;
    logic [63:0] x_s_wdata, x_mem;
    logic [7:0]  x_s_wstrb;
    assign x_awready = x_awvalid;
    assign x_wready  = x_wvalid;
    assign x_arready = x_arvalid;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_have_aw <= 1'b0; x_have_w <= 1'b0; x_bvalid <= 1'b0; x_rvalid <= 1'b0;
            x_s_wdata <= '0; x_s_wstrb <= '0; x_mem <= '0; x_rdata <= '0;
        end else begin
            if (x_awvalid) x_have_aw <= 1'b1;
            if (x_wvalid) begin x_have_w <= 1'b1; x_s_wdata <= x_wdata; x_s_wstrb <= x_wstrb; end
            if (x_bvalid && x_bready) begin
                x_bvalid <= 1'b0; x_have_aw <= 1'b0; x_have_w <= 1'b0;
                for (int k = 0; k < 8; k++)
                    if (x_s_wstrb[k]) x_mem[8*k +: 8] <= x_s_wdata[8*k +: 8];
            end else if (!x_bvalid && (x_have_aw || x_awvalid) && (x_have_w || x_wvalid)) begin
                x_bvalid <= 1'b1;
            end
            if (x_rvalid && x_rready) x_rvalid <= 1'b0;
            else if (x_arvalid) begin x_rvalid <= 1'b1; x_rdata <= x_mem; end
        end
    end

    // ---------------- reference model and helpers ----------------
    logic [31:0] model_mem [0:15];

    function automatic void model_write(input logic [3:0] idx, input logic [31:0] d, input logic [3:0] s);
        for (int k = 0; k < 4; k++)
            if (s[k]) model_mem[idx][8*k +: 8] = d[8*k +: 8];
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_slave(input int aw, input int w, input int b, input int ar, input int r, input logic [1:0] resp);
        cfg_aw_dly = aw; cfg_w_dly = w; cfg_b_dly = b; cfg_ar_dly = ar; cfg_r_dly = r;
        cfg_bresp = resp; cfg_rresp = resp;
    endtask

    // Issue one command on the 32-bit engine; lat = cycles from accept edge to first rsp_valid.
    task automatic do_cmd(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int hold,
                          output logic o_write, output logic [31:0] o_rdata, output logic [1:0] o_resp, output int lat);
        int guard;
        o_write = 1'bx; o_rdata = 'x; o_resp = 'x; lat = -1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        guard = 0;
        while (!cmd_ready && guard < 50) begin @(negedge clk); guard++; end
        if (!cmd_ready) begin
            chk({tag, "_accept"}, 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1 cmd_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 100);
        if (!rsp_valid) begin
            chk({tag, "_rsp_wait"}, 0, 1);
            return;
        end
        o_write = rsp_write; o_rdata = rsp_rdata; o_resp = rsp_resp;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, rsp_valid, 1);
            chk({tag, "_hold_rdata"}, rsp_rdata, o_rdata);
            chk({tag, "_hold_cmd_ready"}, cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        if (hold > 0) chk({tag, "_cmd_ready_at_rsp_ready"}, cmd_ready, 0);
        @(posedge clk); #1 rsp_ready = 1'b0;
        if (hold > 0) begin
            @(negedge clk);
            chk({tag, "_cmd_ready_after"}, cmd_ready, 1);
            chk({tag, "_rsp_valid_after"}, rsp_valid, 0);
        end
    endtask

    task automatic do_cmd64(input string tag, input logic w, input logic [63:0] d, input logic [7:0] s,
                            output logic o_write, output logic [63:0] o_rdata, output logic [1:0] o_resp);
        int guard;
        o_write = 1'bx; o_rdata = 'x; o_resp = 'x;
        @(negedge clk);
        x_cmd_valid = 1'b1; x_cmd_write = w; x_cmd_addr = 32'h20; x_cmd_wdata = d; x_cmd_wstrb = s;
        guard = 0;
        while (!x_cmd_ready && guard < 50) begin @(negedge clk); guard++; end
        if (!x_cmd_ready) begin chk({tag, "_accept"}, 0, 1); x_cmd_valid = 1'b0; return; end
        @(posedge clk); #1 x_cmd_valid = 1'b0;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!x_rsp_valid && guard < 100);
        if (!x_rsp_valid) begin chk({tag, "_rsp_wait"}, 0, 1); return; end
        o_write = x_rsp_write; o_rdata = x_rsp_rdata; o_resp = x_rsp_resp;
        x_rsp_ready = 1'b1;
        @(posedge clk); #1 x_rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_d, w_d, b_d, ar_d, r_d;
        logic [1:0]  sresp;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int          exp_lat;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        o_w;
        logic [31:0] o_d;
        logic [1:0]  o_r;
        int          lat;
        int          a0, w0, b0;
        logic        xo_w;
        logic [63:0] xo_d;
        logic [1:0]  xo_r;

        vecs[0] = '{1'b0, 32'h4, 32'h0,        4'hF, 0, 0, 0, 0, 0, 2'b00, 32'hA5A5_0001, 2'b00, 3};
        vecs[1] = '{1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 0, 2, 1, 0, 0, 2'b00, 32'h0,        2'b00, 6};
        vecs[2] = '{1'b0, 32'h8, 32'h0,        4'hF, 0, 0, 0, 1, 2, 2'b10, 32'hDEADBEEF, 2'b10, 6};
        vecs[3] = '{1'b1, 32'hC, 32'h11223344, 4'h5, 1, 1, 0, 0, 0, 2'b11, 32'h0,        2'b11, 4};
        vecs[4] = '{1'b0, 32'hC, 32'h0,        4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0022_0044, 2'b00, 3};
        vecs[5] = '{1'b1, 32'h4, 32'hFFFFFFFF, 4'h8, 0, 3, 2, 0, 0, 2'b01, 32'h0,        2'b01, 8};
        vecs[6] = '{1'b0, 32'h4, 32'h0,        4'hF, 0, 0, 0, 2, 0, 2'b01, 32'hFFA5_0001, 2'b01, 5};

        for (int i = 0; i < 16; i++) model_mem[i] = '0;
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        x_cmd_valid = 1'b0; x_cmd_write = 1'b0; x_cmd_addr = '0; x_cmd_wdata = '0; x_cmd_wstrb = '0; x_rsp_ready = 1'b0;
        set_slave(0, 0, 0, 0, 0, 2'b00);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, rsp_valid}, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_regs", {m_awaddr, m_wdata}, 0);
        rst_n = 1'b1;
        #1 chk("rst_release_cmd_ready", cmd_ready, 0);
        @(posedge clk); #1 chk("first_edge_cmd_ready", cmd_ready, 1);

        // Sixteen back-to-back writes to 0x0, always-ready slave
        for (int i = 0; i < 16; i++) begin
            do_cmd($sformatf("wr0_%0d", i), 1'b1, 32'h0, i, 4'hF, 0, o_w, o_d, o_r, lat);
            chk($sformatf("wr0_%0d_lat", i), lat, 3);
            chk($sformatf("wr0_%0d_resp", i), o_r, 2'b00);
            chk($sformatf("wr0_%0d_write", i), o_w, 1);
            model_write(4'd0, i, 4'hF);
        end
        do_cmd("rd0", 1'b0, 32'h0, 0, 4'hF, 0, o_w, o_d, o_r, lat);
        chk("rd0_rdata", o_d, 32'h0000_000F);
        chk("rd0_lat", lat, 3);

        // Write with AWREADY delayed 3 cycles, WREADY immediate
        set_slave(3, 0, 0, 0, 0, 2'b00);
        a0 = n_awv; w0 = n_wv; b0 = n_bhs;
        do_cmd("awdly", 1'b1, 32'h4, 32'hA5A5_0001, 4'hF, 0, o_w, o_d, o_r, lat);
        model_write(4'd1, 32'hA5A5_0001, 4'hF);
        chk("awdly_awvalid_cycles", n_awv - a0, 4);
        chk("awdly_wvalid_cycles", n_wv - w0, 1);
        chk("awdly_b_count", n_bhs - b0, 1);
        chk("awdly_rsp_write", o_w, 1);
        chk("awdly_rdata", o_d, 0);
        chk("awdly_lat", lat, 6);

        // Directed table
        for (int i = 0; i < 7; i++) begin
            set_slave(vecs[i].aw_d, vecs[i].w_d, vecs[i].b_d, vecs[i].ar_d, vecs[i].r_d, vecs[i].sresp);
            do_cmd($sformatf("vec%0d", i), vecs[i].w, vecs[i].addr, vecs[i].data, vecs[i].strb, 0, o_w, o_d, o_r, lat);
            if (vecs[i].w) model_write(vecs[i].addr[5:2], vecs[i].data, vecs[i].strb);
            chk($sformatf("vec%0d_write", i), o_w, vecs[i].w);
            chk($sformatf("vec%0d_rdata", i), o_d, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_resp", i), o_r, vecs[i].exp_resp);
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
            chk($sformatf("vec%0d_timeout", i), timeout_err, 0);
        end

        // Response held off for 5 cycles
        set_slave(0, 0, 0, 0, 0, 2'b00);
        do_cmd("hold", 1'b0, 32'h8, 0, 4'hF, 5, o_w, o_d, o_r, lat);
        chk("hold_rdata", o_d, 32'hDEADBEEF);

        // Randomized traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            logic        w;
            logic [3:0]  idx, s;
            logic [31:0] d, exp_d;
            logic [1:0]  br, rr, exp_r;
            int          ad, wd, bd, ard, rd, exp_lat;
            w = 1'($urandom_range(0, 1));
            idx = 4'($urandom_range(0, 15));
            d = $urandom; s = 4'($urandom_range(0, 15));
            ad = $urandom_range(0, 3); wd = $urandom_range(0, 3); bd = $urandom_range(0, 3);
            ard = $urandom_range(0, 3); rd = $urandom_range(0, 3);
            br = 2'($urandom_range(0, 3)); rr = 2'($urandom_range(0, 3));
            cfg_aw_dly = ad; cfg_w_dly = wd; cfg_b_dly = bd; cfg_ar_dly = ard; cfg_r_dly = rd;
            cfg_bresp = br; cfg_rresp = rr;
            exp_d   = w ? 32'h0 : model_mem[idx];
            exp_r   = w ? br : rr;
            exp_lat = w ? (max2(ad, wd) + bd + 3) : (ard + rd + 3);
            do_cmd($sformatf("rnd%0d", i), w, {26'h0, idx, 2'b00}, d, s, $urandom_range(0, 2), o_w, o_d, o_r, lat);
            if (w) model_write(idx, d, s);
            chk($sformatf("rnd%0d_write", i), o_w, w);
            chk($sformatf("rnd%0d_rdata", i), o_d, exp_d);
            chk($sformatf("rnd%0d_resp", i), o_r, exp_r);
            chk($sformatf("rnd%0d_lat", i), lat, exp_lat);
        end
        chk("rnd_timeout", timeout_err, 0);

        // 64-bit data path
        do_cmd64("x_wr", 1'b1, 64'h0123_4567_89AB_CDEF, 8'hF0, xo_w, xo_d, xo_r);
        chk("x_bus_wdata", x_s_wdata, 64'h0123_4567_89AB_CDEF);
        chk("x_bus_wstrb", x_s_wstrb, 8'hF0);
        chk("x_wr_write", xo_w, 1);
        chk("x_wr_resp", xo_r, 2'b00);
        do_cmd64("x_rd", 1'b0, 64'h0, 8'h00, xo_w, xo_d, xo_r);
        chk("x_rd_rdata", xo_d, 64'h0123_4567_0000_0000);
        chk("x_rd_write", xo_w, 0);

        chk("protocol_violations", n_viol, 0);

        // Slave never accepts AW: timeout after 16 busy cycles, then async reset
        set_slave(1000000, 0, 0, 0, 0, 2'b00);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'h1234; cmd_wstrb = 4'hF;
        chk("tmo_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1 cmd_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 16) chk("tmo_before_limit", timeout_err, 0);
            if (c == 17) chk("tmo_at_limit", timeout_err, 1);
        end
        chk("tmo_sticky", timeout_err, 1);
        chk("tmo_awvalid_held", m_awvalid, 1);
        chk("tmo_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_awvalid", m_awvalid, 0);
        chk("arst_timeout", timeout_err, 0);
        chk("arst_busy", busy, 0);
        chk("arst_cmd_ready", cmd_ready, 0);
        chk("arst_awaddr", m_awaddr, 0);
        chk("arst_others", {m_wvalid, m_arvalid, m_bready, m_rready, rsp_valid}, 0);
        set_slave(0, 0, 0, 0, 0, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1 chk("arst_recover_cmd_ready", cmd_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
